// File: rtl/gpio_bus_arbiter.sv
// Two-master arbiter for the GPIO register bus: fixed IDLE/XFER/ACK transactions,
// round-robin between masters, with an optional lock for atomic read-modify-write.
module gpio_bus_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_bus,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic [1:0]        gnt,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i,
  output logic              bus_read,
  output logic              bus_write
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                lock_vld_q, lock_vld_d;
  logic                lock_own_q, lock_own_d;
  logic                own_q, own_d;
  logic                we_q, we_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                m0_ack_q, m0_ack_d;
  logic                m1_ack_q, m1_ack_d;

  logic                grant_vld;
  logic                grant_m1;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Arbitration decision, only consumed in IDLE. A held lock excludes the
  // other master; if the owner has dropped its request the lock is released.
  always_comb begin
    grant_vld = 1'b0;
    grant_m1  = 1'b0;
    if (lock_vld_q) begin
      if (lock_own_q ? m1_req : m0_req) begin
        grant_vld = 1'b1;
        grant_m1  = lock_own_q;
      end
    end else if (m0_req && m1_req) begin
      grant_vld = 1'b1;
      grant_m1  = ptr_q;
    end else if (m0_req) begin
      grant_vld = 1'b1;
      grant_m1  = 1'b0;
    end else if (m1_req) begin
      grant_vld = 1'b1;
      grant_m1  = 1'b1;
    end
  end

  assign sel_we    = grant_m1 ? m1_we    : m0_we;
  assign sel_addr  = grant_m1 ? m1_addr  : m0_addr;
  assign sel_wdata = grant_m1 ? m1_wdata : m0_wdata;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    own_d      = own_q;
    we_d       = we_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (lock_vld_q && !grant_vld) begin
          lock_vld_d = 1'b0;
        end
        if (grant_vld) begin
          own_d   = grant_m1;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          gnt_d   = grant_m1 ? 2'b10 : 2'b01;
          // Strobes are registered here so they are high for exactly the XFER cycle.
          wr_d    = sel_we;
          rd_d    = !sel_we;
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        if (!we_q) begin
          if (own_q) begin
            m1_rdata_d = bus_data_i;
          end else begin
            m0_rdata_d = bus_data_i;
          end
        end
        m0_ack_d = !own_q;
        m1_ack_d = own_q;
        state_d  = S_ACK;
      end

      S_ACK: begin
        ptr_d      = !own_q;
        lock_vld_d = own_q ? m1_lock : m0_lock;
        lock_own_d = own_q;
        gnt_d      = '0;
        state_d    = S_IDLE;
      end

      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
      own_q      <= 1'b0;
      we_q       <= 1'b0;
      gnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      own_q      <= own_d;
      we_q       <= we_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
    end
  end

  assign gnt         = gnt_q;
  assign bus_address = addr_q;
  assign bus_data_o  = wdata_q;
  assign bus_read    = rd_q;
  assign bus_write   = wr_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign m0_ack      = m0_ack_q;
  assign m1_ack      = m1_ack_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Scoreboard bench for gpio_bus_arbiter: expected transactions are queued with the
// stimulus and checked against strobes and acks as the arbiter completes them.
module tb_gpio_bus_arbiter;

  logic        clk_bus = 1'b0;
  logic        rst_n   = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
  logic [7:0]  m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic [31:0] m0_rdata;
  logic        m0_ack;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [7:0]  m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic [31:0] m1_rdata;
  logic        m1_ack;
  logic [1:0]  gnt;
  logic [7:0]  bus_address;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_read, bus_write;

  typedef struct {
    int          m;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  gpio_bus_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk_bus(clk_bus), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .gnt(gnt), .bus_address(bus_address), .bus_data_o(bus_data_o),
    .bus_data_i(bus_data_i), .bus_read(bus_read), .bus_write(bus_write)
  );

  always #5 clk_bus = ~clk_bus;

  // Combinational slave: fixed read pattern per address.
  function automatic logic [31:0] slave_rd(input logic [7:0] a);
    case (a)
      8'h00:   return 32'hDEADBEEF;
      8'h0C:   return 32'h12345678;
      default: return {4{a}} ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  assign bus_data_i = bus_read ? slave_rd(bus_address) : 32'h0;

  task automatic test_reset();
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h33; m0_wdata = '1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h44; m1_wdata = '1;
    repeat (3) @(negedge clk_bus);
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b want=00", gnt); end
    checks++; if (bus_read !== 1'b0) begin failures++; $display("FAIL reset_bus_read got=%b want=0", bus_read); end
    checks++; if (bus_write !== 1'b0) begin failures++; $display("FAIL reset_bus_write got=%b want=0", bus_write); end
    checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL reset_m0_ack got=%b want=0", m0_ack); end
    checks++; if (m1_ack !== 1'b0) begin failures++; $display("FAIL reset_m1_ack got=%b want=0", m1_ack); end
    checks++; if (m0_rdata !== 32'h0) begin failures++; $display("FAIL reset_m0_rdata got=%h want=0", m0_rdata); end
    checks++; if (m1_rdata !== 32'h0) begin failures++; $display("FAIL reset_m1_rdata got=%h want=0", m1_rdata); end
    checks++; if (bus_address !== 8'h0) begin failures++; $display("FAIL reset_bus_address got=%h want=0", bus_address); end
    checks++; if (bus_data_o !== 32'h0) begin failures++; $display("FAIL reset_bus_data_o got=%h want=0", bus_data_o); end
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_wdata = '0; m1_wdata = '0;
  endtask

  task automatic test_single_read();
    txn_t t;
    int strobe_cyc = -1;
    int ack_cyc = -1;
    m0_we = 1'b0; m0_addr = 8'h00; m0_lock = 1'b0; m0_req = 1'b1;
    sb.push_back('{0, 1'b0, 8'h00, 32'h0, 32'hDEADBEEF});
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 10 && ack_cyc < 0; cyc++) begin
      @(negedge clk_bus);
      if ((bus_read || bus_write) && sb.size() > 0) begin
        strobe_cyc = cyc;
        checks++;
        if (bus_read !== 1'b1 || bus_write !== 1'b0 || bus_address !== sb[0].addr || gnt !== 2'b01) begin
          failures++;
          $display("FAIL rd_strobe got rd=%b wr=%b addr=%h gnt=%b want rd=1 wr=0 addr=%h gnt=01",
                   bus_read, bus_write, bus_address, gnt, sb[0].addr);
        end
      end
      checks++; if (m1_ack !== 1'b0) begin failures++; $display("FAIL rd_m1_ack got=%b want=0", m1_ack); end
      if (m0_ack === 1'b1 && sb.size() > 0) begin
        ack_cyc = cyc;
        m0_req  = 1'b0;
        t = sb.pop_front();
        checks++; if (m0_rdata !== t.rdata) begin failures++; $display("FAIL rd_data got=%h want=%h", m0_rdata, t.rdata); end
      end
    end
    checks++; if (strobe_cyc != 1) begin failures++; $display("FAIL rd_strobe_cycle got=%0d want=1", strobe_cyc); end
    checks++; if (ack_cyc != 2) begin failures++; $display("FAIL rd_ack_cycle got=%0d want=2", ack_cyc); end
    repeat (4) begin
      @(negedge clk_bus);
      checks++; if (m0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_hold got=%h want=deadbeef", m0_rdata); end
      checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || gnt !== 2'b00) begin
        failures++; $display("FAIL rd_after got m0_ack=%b m1_ack=%b gnt=%b want 0 0 00", m0_ack, m1_ack, gnt);
      end
    end
  endtask

  task automatic test_single_write();
    txn_t t;
    int strobe_cyc = -1;
    int ack_cyc = -1;
    int nwr = 0;
    m1_we = 1'b1; m1_addr = 8'h04; m1_wdata = 32'h0000_00FF; m1_lock = 1'b0; m1_req = 1'b1;
    sb.push_back('{1, 1'b1, 8'h04, 32'h0000_00FF, 32'h0});
    for (int cyc = 1; cyc <= 10 && ack_cyc < 0; cyc++) begin
      @(negedge clk_bus);
      if (bus_write) nwr++;
      if ((bus_read || bus_write) && sb.size() > 0) begin
        strobe_cyc = cyc;
        checks++;
        if (bus_write !== 1'b1 || bus_read !== 1'b0 || bus_address !== sb[0].addr ||
            bus_data_o !== sb[0].wdata || gnt !== 2'b10) begin
          failures++;
          $display("FAIL wr_strobe got wr=%b rd=%b addr=%h data=%h gnt=%b want wr=1 rd=0 addr=%h data=%h gnt=10",
                   bus_write, bus_read, bus_address, bus_data_o, gnt, sb[0].addr, sb[0].wdata);
        end
      end
      checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL wr_m0_ack got=%b want=0", m0_ack); end
      if (m1_ack === 1'b1 && sb.size() > 0) begin
        ack_cyc = cyc;
        m1_req  = 1'b0;
        t = sb.pop_front();
        checks++; if (m1_rdata !== t.rdata) begin failures++; $display("FAIL wr_m1_rdata got=%h want=%h", m1_rdata, t.rdata); end
      end
    end
    checks++; if (strobe_cyc != 1) begin failures++; $display("FAIL wr_strobe_cycle got=%0d want=1", strobe_cyc); end
    checks++; if (ack_cyc != 2) begin failures++; $display("FAIL wr_ack_cycle got=%0d want=2", ack_cyc); end
    checks++; if (nwr != 1) begin failures++; $display("FAIL wr_strobe_count got=%0d want=1", nwr); end
    repeat (2) @(negedge clk_bus);
    checks++; if (m1_rdata !== 32'h0) begin failures++; $display("FAIL wr_m1_rdata_hold got=%h want=0", m1_rdata); end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_m0_rdata_hold got=%h want=deadbeef", m0_rdata); end
  endtask

  task automatic test_contention();
    txn_t t;
    int last_ack = -1;
    int nack = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_bus);
    m0_we = 1'b0; m0_addr = 8'h10; m0_lock = 1'b0; m0_req = 1'b1;
    m1_we = 1'b0; m1_addr = 8'h20; m1_lock = 1'b0; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) sb.push_back('{0, 1'b0, 8'h10, 32'h0, slave_rd(8'h10)});
      else            sb.push_back('{1, 1'b0, 8'h20, 32'h0, slave_rd(8'h20)});
    end
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 30 && sb.size() > 0; cyc++) begin
      @(negedge clk_bus);
      checks++; if (bus_read && bus_write) begin failures++; $display("FAIL cont_overlap got rd=1 wr=1 want not both"); end
      checks++; if (m0_ack && m1_ack) begin failures++; $display("FAIL cont_dual_ack got both acks want at most one"); end
      if (m0_ack || m1_ack) begin
        t = sb.pop_front();
        nack++;
        checks++; if ((m1_ack ? 1 : 0) != t.m) begin failures++; $display("FAIL cont_order ack#%0d got=m%0d want=m%0d", nack, m1_ack ? 1 : 0, t.m); end
        checks++; if ((t.m == 1 ? m1_rdata : m0_rdata) !== t.rdata) begin
          failures++; $display("FAIL cont_rdata ack#%0d got=%h want=%h", nack, t.m == 1 ? m1_rdata : m0_rdata, t.rdata);
        end
        if (last_ack >= 0) begin
          checks++; if (cyc - last_ack != 3) begin failures++; $display("FAIL cont_spacing got=%0d want=3", cyc - last_ack); end
        end
        last_ack = cyc;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    checks++; if (nack != 4) begin failures++; $display("FAIL cont_ack_count got=%0d want=4", nack); end
    sb.delete();
    repeat (3) @(negedge clk_bus);
  endtask

  task automatic test_lock_rmw();
    txn_t t;
    int last_ack = -1;
    bit clr_lock = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_bus);
    m0_we = 1'b0; m0_addr = 8'h30; m0_lock = 1'b0; m0_req = 1'b0;
    m1_we = 1'b0; m1_addr = 8'h0C; m1_lock = 1'b1; m1_req = 1'b1;
    sb.push_back('{1, 1'b0, 8'h0C, 32'h0, 32'h12345678});
    sb.push_back('{1, 1'b1, 8'h0C, 32'h1234_56F8, 32'h0});
    sb.push_back('{0, 1'b0, 8'h30, 32'h0, slave_rd(8'h30)});
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 30 && sb.size() > 0; cyc++) begin
      @(negedge clk_bus);
      if ((bus_read || bus_write) && sb.size() > 0) begin
        checks++;
        if (gnt !== (sb[0].m == 1 ? 2'b10 : 2'b01) || bus_write !== sb[0].we || bus_address !== sb[0].addr ||
            (sb[0].we && bus_data_o !== sb[0].wdata)) begin
          failures++;
          $display("FAIL lock_strobe got gnt=%b wr=%b addr=%h data=%h want m%0d wr=%b addr=%h data=%h",
                   gnt, bus_write, bus_address, bus_data_o, sb[0].m, sb[0].we, sb[0].addr, sb[0].wdata);
        end
      end
      if (m0_ack || m1_ack) begin
        t = sb.pop_front();
        checks++; if ((m1_ack ? 1 : 0) != t.m) begin failures++; $display("FAIL lock_order got=m%0d want=m%0d", m1_ack ? 1 : 0, t.m); end
        if (last_ack >= 0) begin
          checks++; if (cyc - last_ack != 3) begin failures++; $display("FAIL lock_spacing got=%0d want=3", cyc - last_ack); end
        end
        last_ack = cyc;
        checks++;
        if ((t.m == 1 ? m1_rdata : m0_rdata) !== (t.m == 1 ? 32'h12345678 : t.rdata)) begin
          failures++; $display("FAIL lock_rdata got=%h want=%h", t.m == 1 ? m1_rdata : m0_rdata,
                               t.m == 1 ? 32'h12345678 : t.rdata);
        end
        if (t.m == 1 && !t.we) begin
          m1_we = 1'b1; m1_wdata = 32'h1234_56F8; clr_lock = 1'b1;
        end else if (t.m == 1) begin
          m1_req = 1'b0;
        end else begin
          m0_req = 1'b0;
        end
      end else if (clr_lock) begin
        m1_lock = 1'b0; clr_lock = 1'b0;
      end
      if (cyc == 1) m0_req = 1'b1;
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL lock_timeout got pending=%0d want=0", sb.size()); end
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk_bus);
  endtask

  task automatic test_reset_midop();
    txn_t t;
    bit seen = 1'b0;
    int ack_cyc = -1;
    m0_we = 1'b0; m0_addr = 8'h40; m0_lock = 1'b0; m0_req = 1'b1;
    for (int cyc = 1; cyc <= 10 && !seen; cyc++) begin
      @(negedge clk_bus);
      if (bus_read) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_mid_no_strobe got=0 want=1"); end
    rst_n = 1'b0;
    @(negedge clk_bus);
    checks++; if (bus_read !== 1'b0 || bus_write !== 1'b0) begin failures++; $display("FAIL rst_mid_strobe got rd=%b wr=%b want 0 0", bus_read, bus_write); end
    checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL rst_mid_ack got=%b want=0", m0_ack); end
    checks++; if (m0_rdata !== 32'h0) begin failures++; $display("FAIL rst_mid_rdata got=%h want=0", m0_rdata); end
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL rst_mid_gnt got=%b want=00", gnt); end
    m0_req = 1'b0;
    @(negedge clk_bus);
    checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL rst_mid_late_ack got=%b want=0", m0_ack); end
    m1_we = 1'b1; m1_addr = 8'h50; m1_wdata = 32'h77; m1_lock = 1'b0; m1_req = 1'b1;
    sb.push_back('{1, 1'b1, 8'h50, 32'h77, 32'h0});
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 10 && ack_cyc < 0; cyc++) begin
      @(negedge clk_bus);
      if ((bus_read || bus_write) && sb.size() > 0) begin
        checks++;
        if (cyc != 1 || gnt !== 2'b10 || bus_write !== 1'b1 || bus_address !== sb[0].addr || bus_data_o !== sb[0].wdata) begin
          failures++; $display("FAIL rst_mid_m1_strobe got cyc=%0d gnt=%b wr=%b addr=%h data=%h want cyc=1 gnt=10 wr=1 addr=%h data=%h",
                               cyc, gnt, bus_write, bus_address, bus_data_o, sb[0].addr, sb[0].wdata);
        end
      end
      if (m0_ack) begin failures++; checks++; $display("FAIL rst_mid_m0_ack got=1 want=0"); end
      if (m1_ack && sb.size() > 0) begin
        ack_cyc = cyc; m1_req = 1'b0; t = sb.pop_front();
      end
    end
    checks++; if (ack_cyc != 2) begin failures++; $display("FAIL rst_mid_m1_ack_cycle got=%0d want=2", ack_cyc); end
    m1_we = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk_bus);
  endtask

  task automatic test_lock_abandon();
    txn_t t;
    int ack0 = -100;
    int ack1 = -1;
    int strobe1 = -1;
    m0_we = 1'b0; m0_addr = 8'h60; m0_lock = 1'b1; m0_req = 1'b1;
    m1_we = 1'b0; m1_addr = 8'h70; m1_lock = 1'b0; m1_req = 1'b0;
    sb.push_back('{0, 1'b0, 8'h60, 32'h0, slave_rd(8'h60)});
    sb.push_back('{1, 1'b0, 8'h70, 32'h0, slave_rd(8'h70)});
    for (int cyc = 1; cyc <= 20 && sb.size() > 0; cyc++) begin
      @(negedge clk_bus);
      if (cyc == ack0 + 1 || cyc == ack0 + 2) begin
        checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL abandon_idle_gnt cyc=%0d got=%b want=00", cyc - ack0, gnt); end
      end
      if (cyc == ack0 + 1) m0_lock = 1'b0;
      if ((bus_read || bus_write) && sb.size() > 0) begin
        if (sb[0].m == 1) strobe1 = cyc;
        checks++;
        if (gnt !== (sb[0].m == 1 ? 2'b10 : 2'b01) || bus_read !== 1'b1 || bus_address !== sb[0].addr) begin
          failures++; $display("FAIL abandon_strobe got gnt=%b rd=%b addr=%h want m%0d rd=1 addr=%h",
                               gnt, bus_read, bus_address, sb[0].m, sb[0].addr);
        end
      end
      if (m0_ack || m1_ack) begin
        t = sb.pop_front();
        checks++; if ((m1_ack ? 1 : 0) != t.m) begin failures++; $display("FAIL abandon_order got=m%0d want=m%0d", m1_ack ? 1 : 0, t.m); end
        checks++; if ((t.m == 1 ? m1_rdata : m0_rdata) !== t.rdata) begin
          failures++; $display("FAIL abandon_rdata got=%h want=%h", t.m == 1 ? m1_rdata : m0_rdata, t.rdata);
        end
        if (t.m == 0) begin
          ack0 = cyc; m0_req = 1'b0; m1_req = 1'b1;
        end else begin
          ack1 = cyc; m1_req = 1'b0;
        end
      end
    end
    checks++; if (strobe1 - ack0 != 3) begin failures++; $display("FAIL abandon_m1_strobe_delay got=%0d want=3", strobe1 - ack0); end
    checks++; if (ack1 - ack0 != 4) begin failures++; $display("FAIL abandon_m1_ack_delay got=%0d want=4", ack1 - ack0); end
    m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk_bus);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_lock_rmw();
    test_reset_midop();
    test_lock_abandon();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
